// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: first-word-fall-through FIFO
// with occupancy count, registered full/empty flags and a sticky overflow flag.
module uart_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              rd,
   output logic [DATA_W-1:0] r_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   input  logic              clr_ovf
);
   localparam int              DEPTH  = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE_C  = (ADDR_W+1)'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              ovf_q, ovf_d;

   logic rd_ok;
   logic wr_ok;
   logic drop;

   // A write into a full FIFO is still accepted when a pop frees the head slot
   // in the same cycle; only an unpaired write at full is dropped.
   always_comb begin
      rd_ok    = rd & ~empty_q;
      wr_ok    = wr & (~full_q | rd_ok);
      drop     = wr & full_q & ~rd_ok;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      empty_d  = empty_q;
      full_d   = full_q;
      ovf_d    = ovf_q;

      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end

      case ({wr_ok, rd_ok})
         2'b10: begin
            count_d = count_q + ONE_C;
            empty_d = 1'b0;
            full_d  = (count_q == LAST_C);
         end
         2'b01: begin
            count_d = count_q - ONE_C;
            full_d  = 1'b0;
            empty_d = (count_q == ONE_C);
         end
         default: begin
         end
      endcase

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is deliberately left uninitialised by reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok) begin
         mem_q[wr_ptr_q] <= w_data;
      end
   end

   assign r_data   = mem_q[rd_ptr_q];
   assign empty    = empty_q;
   assign full     = full_q;
   assign count    = count_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: accepted bytes go into a scoreboard queue,
// a monitor pops and compares r_data on every effective pop.
module tb_uart_rx_fifo;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] w_data = '0;
   logic       rd = 1'b0;
   logic [7:0] r_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic       clr_ovf = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q [$];

   uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .w_data   (w_data),
      .rd       (rd),
      .r_data   (r_data),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s = 0x%0h", name, act);
      end
   endtask

   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr      = w;
      w_data  = d;
      rd      = r;
      clr_ovf = c;
      @(posedge clk);
      #1;
      wr      = 1'b0;
      rd      = 1'b0;
      clr_ovf = 1'b0;
   endtask

   task automatic put(input logic [7:0] d);
      exp_q.push_back(d);
      step(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic do_reset(input logic w);
      reset = 1'b1;
      step(w, 8'hEE, w, w);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic status(input string tag, input int e, input int f, input int n, input int o);
      chk({tag, ".empty"}, int'(empty), e);
      chk({tag, ".full"}, int'(full), f);
      chk({tag, ".count"}, int'(count), n);
      chk({tag, ".overflow"}, int'(overflow), o);
   endtask

   // Monitor: an effective pop presents the scoreboard head on r_data.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && rd && !empty) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected got 0x%0h expected none", r_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (r_data !== e) begin
                  errors++;
                  $display("FAIL pop_data got 0x%0h expected 0x%0h", r_data, e);
               end else begin
                  $display("ok   pop_data = 0x%0h", r_data);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // 1: reset then idle, with a write attempted during reset (reset wins)
      do_reset(1'b1);
      repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);
      status("t1", 1, 0, 0, 0);

      // 2: two bytes, FWFT head, pops
      put(8'hA5);
      put(8'h3C);
      chk("t2.r_data", int'(r_data), 8'hA5);
      chk("t2.count", int'(count), 2);
      pop();
      chk("t2.r_data_after_pop", int'(r_data), 8'h3C);
      chk("t2.count_after_pop", int'(count), 1);
      pop();
      status("t2.end", 1, 0, 0, 0);
      pop();
      status("t2.rd_empty", 1, 0, 0, 0);

      // 3: fill, overflow on 17th write, drain
      for (int i = 0; i < 16; i++) put(8'(i));
      status("t3.full", 0, 1, 16, 0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      status("t3.ovf", 0, 1, 16, 1);
      for (int i = 0; i < 16; i++) pop();
      status("t3.drained", 1, 0, 0, 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t3.clr_ovf", int'(overflow), 0);

      // 5: simultaneous write+pop at full and at empty
      for (int i = 0; i < 16; i++) put(8'(8'h10 + i));
      exp_q.push_back(8'h55);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      status("t5.full_wr_rd", 0, 1, 16, 0);
      for (int i = 0; i < 16; i++) pop();
      status("t5.drained", 1, 0, 0, 0);
      exp_q.push_back(8'h66);
      step(1'b1, 8'h66, 1'b1, 1'b0);
      chk("t5.empty_wr_rd.count", int'(count), 1);
      chk("t5.empty_wr_rd.r_data", int'(r_data), 8'h66);
      pop();

      // 6: clear collides with a drop, then mid-stream reset
      for (int i = 0; i < 16; i++) put(8'(8'h20 + i));
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      status("t6.drop_vs_clr", 0, 1, 16, 1);
      for (int i = 0; i < 9; i++) pop();
      status("t6.pre_reset", 0, 0, 7, 1);
      do_reset(1'b0);
      status("t6.post_reset", 1, 0, 0, 0);

      // 4: pointer wrap
      for (int i = 0; i < 12; i++) put(8'(8'h40 + i));
      for (int i = 0; i < 12; i++) pop();
      for (int i = 0; i < 10; i++) put(8'(8'h80 + i));
      chk("t4.count", int'(count), 10);
      chk("t4.head", int'(r_data), 8'h80);
      for (int i = 0; i < 10; i++) pop();
      status("t4.end", 1, 0, 0, 0);

      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("scoreboard_left", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
